// File: rtl/sw_seq_loader_if.sv
// Host-side and core-side signal bundle of the sw sequence loader.
// The slave modport is the loader's view; the master modport is the host/core view.
interface sw_seq_loader_if #(
  parameter int DEPTH   = 16,
  parameter int SCORE_W = 7
);
  localparam int LEN_W = $clog2(DEPTH) + 1;

  logic               in_valid;
  logic               in_ready;
  logic [7:0]         in_query;
  logic [7:0]         in_db;
  logic               in_last;
  logic               sw_ready;
  logic               sw_start;
  logic [7:0]         query_seq_in;
  logic [7:0]         database_seq_in;
  logic               seq_valid;
  logic               sw_output_valid;
  logic [SCORE_W-1:0] sw_score;
  logic               res_valid;
  logic               res_ready;
  logic [SCORE_W-1:0] res_score;
  logic [LEN_W-1:0]   res_len;
  logic               res_timeout;
  logic               busy;

  modport slave (
    input  in_valid, in_query, in_db, in_last, sw_ready, sw_output_valid, sw_score, res_ready,
    output in_ready, sw_start, query_seq_in, database_seq_in, seq_valid,
           res_valid, res_score, res_len, res_timeout, busy
  );

  modport master (
    output in_valid, in_query, in_db, in_last, sw_ready, sw_output_valid, sw_score, res_ready,
    input  in_ready, sw_start, query_seq_in, database_seq_in, seq_valid,
           res_valid, res_score, res_len, res_timeout, busy
  );
endinterface

// File: rtl/sw_seq_loader.sv
// Buffers one job of query/database pairs, starts the sw core, streams the pairs
// into it and hands the captured score (or a timeout) back to the host.
//
// state      | meaning
// S_IDLE     | accepting host pairs into the buffer
// S_START    | job buffered, waiting for sw_ready to pulse sw_start
// S_STREAM   | driving buffered pairs into the core back-to-back
// S_WAIT_RES | waiting for sw_output_valid, bounded by TIMEOUT_CYC
// S_RESULT   | result held for the host until res_ready
module sw_seq_loader #(
  parameter int DEPTH       = 16,
  parameter int SCORE_W     = 7,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic           clk,
  input  logic           rst,
  sw_seq_loader_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int LEN_W = IDX_W + 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYC);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_STREAM,
    S_WAIT_RES,
    S_RESULT
  } state_t;

  state_t r_state;
  state_t w_state_nx;

  logic [7:0]         r_q_buf [DEPTH];
  logic [7:0]         r_d_buf [DEPTH];
  logic [LEN_W-1:0]   r_count;
  logic [LEN_W-1:0]   r_rd_ptr;
  logic [TO_W-1:0]    r_to_cnt;
  logic               r_in_ready;
  logic               r_sw_start;
  logic [7:0]         r_query;
  logic [7:0]         r_db;
  logic               r_seq_valid;
  logic               r_res_valid;
  logic [SCORE_W-1:0] r_res_score;
  logic [LEN_W-1:0]   r_res_len;
  logic               r_res_timeout;
  logic               r_busy;

  logic w_accept;
  logic w_last_beat;
  logic w_stream_done;
  logic w_timeout;
  logic w_res_hs;

  // in_ready is only ever high in S_IDLE, so it doubles as the state qualifier
  assign w_accept      = bus.in_valid & r_in_ready;
  assign w_last_beat   = w_accept & (bus.in_last | (r_count == LEN_W'(DEPTH - 1)));
  assign w_stream_done = (r_rd_ptr == r_count);
  assign w_timeout     = (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));
  assign w_res_hs      = r_res_valid & bus.res_ready;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:     if (w_last_beat) w_state_nx = S_START;
      S_START:    if (bus.sw_ready) w_state_nx = S_STREAM;
      S_STREAM:   if (w_stream_done) w_state_nx = S_WAIT_RES;
      S_WAIT_RES: if (bus.sw_output_valid || w_timeout) w_state_nx = S_RESULT;
      S_RESULT:   if (w_res_hs) w_state_nx = S_IDLE;
      default:    w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_q_buf[r_count[IDX_W-1:0]] <= bus.in_query;
      r_d_buf[r_count[IDX_W-1:0]] <= bus.in_db;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count       <= '0;
      r_rd_ptr      <= '0;
      r_to_cnt      <= '0;
      r_in_ready    <= 1'b1;
      r_sw_start    <= 1'b0;
      r_query       <= '0;
      r_db          <= '0;
      r_seq_valid   <= 1'b0;
      r_res_valid   <= 1'b0;
      r_res_score   <= '0;
      r_res_len     <= '0;
      r_res_timeout <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_sw_start <= 1'b0;
      r_busy     <= (w_state_nx != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_count <= r_count + LEN_W'(1);
            if (w_last_beat) r_in_ready <= 1'b0;
          end
        end
        S_START: begin
          if (bus.sw_ready) begin
            r_sw_start <= 1'b1;
            r_rd_ptr   <= '0;
          end
        end
        S_STREAM: begin
          // the start-pulse cycle itself presents pair 0 at its closing edge
          if (w_stream_done) begin
            r_seq_valid <= 1'b0;
            r_query     <= '0;
            r_db        <= '0;
            r_to_cnt    <= '0;
          end else begin
            r_seq_valid <= 1'b1;
            r_query     <= r_q_buf[r_rd_ptr[IDX_W-1:0]];
            r_db        <= r_d_buf[r_rd_ptr[IDX_W-1:0]];
            r_rd_ptr    <= r_rd_ptr + LEN_W'(1);
          end
        end
        S_WAIT_RES: begin
          if (bus.sw_output_valid) begin
            r_res_valid   <= 1'b1;
            r_res_score   <= bus.sw_score;
            r_res_timeout <= 1'b0;
            r_res_len     <= r_count;
          end else if (w_timeout) begin
            r_res_valid   <= 1'b1;
            r_res_score   <= '0;
            r_res_timeout <= 1'b1;
            r_res_len     <= r_count;
          end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
          end
        end
        S_RESULT: begin
          if (w_res_hs) begin
            r_res_valid <= 1'b0;
            r_count     <= '0;
            r_in_ready  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready        = r_in_ready;
  assign bus.sw_start        = r_sw_start;
  assign bus.query_seq_in    = r_query;
  assign bus.database_seq_in = r_db;
  assign bus.seq_valid       = r_seq_valid;
  assign bus.res_valid       = r_res_valid;
  assign bus.res_score       = r_res_score;
  assign bus.res_len         = r_res_len;
  assign bus.res_timeout     = r_res_timeout;
  assign bus.busy            = r_busy;
endmodule
